// File: rtl/writeback.sv
// Writeback stage: 15x64 register file with two write ports (E, M), two
// combinational read ports, a RUN/HALT/FAULT status FSM and a retired-instruction
// counter. Define WB_BYPASS_EN to forward same-cycle writes onto the read ports.
module writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  W_icode,
  input  logic [1:0]  W_stat,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  output logic [63:0] d_rvalA,
  output logic [63:0] d_rvalB,
  output logic [1:0]  Stat,
  output logic        halted,
  output logic [31:0] retired
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 15;
  localparam int unsigned AW   = 4;
  localparam int unsigned CW   = 32;

  localparam logic [AW-1:0] RNONE      = 4'hF;
  localparam logic [3:0]    ICODE_NOP  = 4'h1;
  localparam logic [1:0]    STAT_AOK   = 2'd0;
  localparam logic [1:0]    STAT_HLT   = 2'd1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              state;
  logic [XLEN-1:0]     regs [NREG];
  logic                wr_en;
  logic                wr_e;
  logic                wr_m;

  // Only a good instruction retiring in RUN may touch architectural state.
  assign wr_en = (state == S_RUN) && (W_stat == STAT_AOK);
  assign wr_e  = wr_en && (W_dstE != RNONE);
  assign wr_m  = wr_en && (W_dstM != RNONE);

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = '0;
    if (addr != RNONE) begin
      val = regs[addr];
`ifdef WB_BYPASS_EN
      if (wr_m && (W_dstM == addr)) begin
        val = W_valM;
      end else if (wr_e && (W_dstE == addr)) begin
        val = W_valE;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    d_rvalA = rd_port(d_srcA);
    d_rvalB = rd_port(d_srcB);
  end

  // Stat doubles as the latched fault code once the FSM reaches FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
      state   <= S_RUN;
      Stat    <= STAT_AOK;
      halted  <= 1'b0;
      retired <= '0;
    end else if (state == S_RUN) begin
      if (W_stat == STAT_AOK) begin
        for (int i = 0; i < int'(NREG); i++) begin
          if (wr_m && (W_dstM == AW'(i))) begin
            regs[i] <= W_valM;
          end else if (wr_e && (W_dstE == AW'(i))) begin
            regs[i] <= W_valE;
          end
        end
        if (W_icode != ICODE_NOP) begin
          retired <= retired + CW'(1);
        end
      end else if (W_stat == STAT_HLT) begin
        state  <= S_HALT;
        Stat   <= STAT_HLT;
        halted <= 1'b1;
      end else begin
        state  <= S_FAULT;
        Stat   <= W_stat;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus random traffic
// compared against an array-based architectural model.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  W_icode;
  logic [1:0]  W_stat;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [1:0]  Stat;
  logic        halted;
  logic [31:0] retired;

  writeback dut (
    .clk(clk), .rst(rst),
    .W_icode(W_icode), .W_stat(W_stat),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .Stat(Stat), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Architectural model: 0=running, 1=halted, 2=faulted
  logic [63:0] m_regs [15];
  int          m_state;
  logic [1:0]  m_stat;
  logic [31:0] m_ret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_state = 0;
    m_stat  = 2'd0;
    m_ret   = '0;
  endtask

  function automatic logic [63:0] exp_rd(input logic [3:0] a);
    if (a == 4'hF) return '0;
`ifdef WB_BYPASS_EN
    if (m_state == 0 && W_stat == 2'd0) begin
      if (W_dstM == a) return W_valM;
      if (W_dstE == a) return W_valE;
    end
`endif
    return m_regs[a];
  endfunction

  task automatic model_edge();
    if (m_state != 0) return;
    case (W_stat)
      2'd0: begin
        if (W_dstE != 4'hF) m_regs[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_regs[W_dstM] = W_valM;
        if (W_icode != 4'h1) m_ret = m_ret + 32'd1;
      end
      2'd1: begin m_state = 1; m_stat = 2'd1; end
      default: begin m_state = 2; m_stat = W_stat; end
    endcase
  endtask

  task automatic set_idle();
    W_icode = 4'h1; W_stat = 2'd0;
    W_dstE = 4'hF; W_valE = '0;
    W_dstM = 4'hF; W_valM = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic [3:0] ic, input logic [1:0] st,
                      input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm,
                      input logic [3:0] sa, input logic [3:0] sb);
    W_icode = ic; W_stat = st;
    W_dstE = de; W_valE = ve;
    W_dstM = dm; W_valM = vm;
    d_srcA = sa; d_srcB = sb;
    #1;
    chk("rvalA", d_rvalA, exp_rd(sa));
    chk("rvalB", d_rvalB, exp_rd(sb));
    @(posedge clk);
    model_edge();
    #1;
    chk("Stat", 64'(Stat), 64'(m_stat));
    chk("halted", 64'(halted), 64'(m_state != 0));
    chk("retired", 64'(retired), 64'(m_ret));
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle while a write is presented; held across one edge.
  task automatic do_reset();
    W_icode = 4'h6; W_stat = 2'd0;
    W_dstE = 4'h2; W_valE = 64'hDEAD;
    W_dstM = 4'h5; W_valM = 64'hBEEF;
    rst = 1'b1;
    #1;
    chk("rst_async_stat", 64'(Stat), 64'd0);
    chk("rst_async_halted", 64'(halted), 64'd0);
    chk("rst_async_retired", 64'(retired), 64'd0);
    @(posedge clk);
    #1;
    set_idle();
    for (int i = 0; i < 16; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(15 - i);
      #1;
      chk("rst_regA", d_rvalA, 64'd0);
      chk("rst_regB", d_rvalB, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1;
    set_idle();
    d_srcA = 4'h0; d_srcB = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // First write after reset: reg0 <- 5, one counted instruction
    step(4'h6, 2'd0, 4'h0, 64'h5, 4'hF, 64'h0, 4'h0, 4'h0);
    step(4'h1, 2'd0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 4'h4);
    chk("req033_reg0", d_rvalA, 64'h5);
    chk("req033_retired", 64'(retired), 64'd1);

    // Both ports to reg4: M value wins
    step(4'hB, 2'd0, 4'h4, 64'h100, 4'h4, 64'h200, 4'h4, 4'h0);
    step(4'h1, 2'd0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h4, 4'h0);
    chk("req034_reg4", d_rvalA, 64'h200);

    // Write to RNONE ignored; nop not counted
    step(4'h6, 2'd0, 4'hF, 64'hFF, 4'hF, 64'h0, 4'hF, 4'h0);
    step(4'h1, 2'd0, 4'h3, 64'h33, 4'hF, 64'h0, 4'hF, 4'h4);
    chk("req035_rnone", d_rvalA, 64'h0);

    // Same-cycle read of a register being written through port M
    step(4'h5, 2'd0, 4'hF, 64'h0, 4'h3, 64'h7, 4'h0, 4'h3);
    step(4'h1, 2'd0, 4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 4'h3);
    chk("req038_next", d_rvalB, 64'h7);

    // Random AOK traffic
    for (int n = 0; n < 200; n++) begin
      step(4'($urandom_range(0, 11)), 2'd0,
           4'($urandom_range(0, 15)), r64(),
           4'($urandom_range(0, 15)), r64(),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Counter wrap
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    m_ret = 32'hFFFF_FFFF;
    step(4'h6, 2'd0, 4'h7, 64'h77, 4'hF, 64'h0, 4'h7, 4'h0);
    chk("req037_wrap", 64'(retired), 64'd0);
    chk("req037_stat", 64'(Stat), 64'd0);

    // ADR fault: no write, sticky, inputs ignored afterwards
    step(4'h5, 2'd2, 4'h1, 64'h1111, 4'hF, 64'h0, 4'h1, 4'h0);
    chk("req036_stat", 64'(Stat), 64'd2);
    chk("req036_halted", 64'(halted), 64'd1);
    step(4'h6, 2'd0, 4'h1, 64'h2222, 4'h1, 64'h3333, 4'h1, 4'h1);
    step(4'h6, 2'd1, 4'h2, 64'h4444, 4'hF, 64'h0, 4'h1, 4'h2);
    step(4'h6, 2'd3, 4'h2, 64'h4444, 4'hF, 64'h0, 4'h1, 4'h2);
    chk("req036_stat_sticky", 64'(Stat), 64'd2);

    // INS fault code latched
    do_reset();
    step(4'h6, 2'd0, 4'h2, 64'hAB, 4'hF, 64'h0, 4'h2, 4'h0);
    step(4'h6, 2'd3, 4'h2, 64'hCD, 4'h3, 64'hEF, 4'h2, 4'h3);
    chk("ins_stat", 64'(Stat), 64'd3);

    // HLT: sticky, blocks its own write
    do_reset();
    step(4'h0, 2'd1, 4'h6, 64'h66, 4'h6, 64'h66, 4'h6, 4'h0);
    chk("hlt_stat", 64'(Stat), 64'd1);
    step(4'h6, 2'd0, 4'h6, 64'h99, 4'hF, 64'h0, 4'h6, 4'h6);

    // Random traffic with occasional non-AOK status
    do_reset();
    for (int n = 0; n < 150; n++) begin
      step(4'($urandom_range(0, 11)),
           ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           4'($urandom_range(0, 15)), r64(),
           4'($urandom_range(0, 15)), r64(),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 W_icode  input  4  retiring instruction code (0=halt, 1=nop).
REQ-005 W_stat  input  2  retiring instruction status: 0=AOK, 1=HLT, 2=ADR, 3=INS.
REQ-006 W_dstE / W_valE  input  4 / 64  ALU-result destination register and value; 4'hF=RNONE.
REQ-007 W_dstM / W_valM  input  4 / 64  memory-result destination register and value; 4'hF=RNONE.
REQ-008 d_srcA / d_srcB  input  4 / 4  decode read addresses.
REQ-009 d_rvalA / d_rvalB  output  64 / 64  decode read data (combinational).
REQ-010 Stat  output  2  processor status, same encoding as W_stat.
REQ-011 halted  output  1  high when the FSM is in HALT or FAULT.
REQ-012 retired  output  32  count of retired instructions.

Function
REQ-013 Register file: 15 x 64-bit registers, indices 0-14 (%rax..%r14); index 15 is RNONE, holds no storage and always reads 0.
REQ-014 Write enable: writes occur at the rising clk edge only when FSM=RUN and W_stat=AOK.
REQ-015 A write to RNONE SHALL be ignored.
REQ-016 Port E writes W_valE to W_dstE; port M writes W_valM to W_dstM; both may write in the same cycle.
REQ-017 If W_dstE==W_dstM!=RNONE, W_valM SHALL be written (M wins, popq %rsp semantics).
REQ-018 Reads: d_rvalA=reg[d_srcA] and d_rvalB=reg[d_srcB], with zero cycles of latency.
REQ-019 FSM states: RUN, HALT, FAULT.
REQ-020 FSM transitions from RUN: W_stat=AOK -> RUN; W_stat=HLT -> HALT; W_stat=ADR or INS -> FAULT, latching the code into fault_code.
REQ-021 HALT and FAULT SHALL be sticky until rst.
REQ-022 W_* inputs SHALL be ignored in HALT and FAULT: no writes, no count, no transition.
REQ-023 The instruction that causes the HLT/ADR/INS transition SHALL NOT write registers.
REQ-024 Stat outputs: RUN -> 0; HALT -> 1; FAULT -> fault_code. Stat is registered and updates on the edge that changes the state.
REQ-025 retired SHALL increment by 1 on each edge where FSM=RUN, W_stat=AOK and W_icode!=1 (nops and bubbles are not counted).
REQ-026 retired SHALL wrap from 32'hFFFFFFFF to 0 without affecting any other state.

Reset
REQ-027 On rst assertion, immediately and regardless of clk: all 15 registers SHALL be 0, FSM=RUN, Stat=0, halted=0, retired=0, fault_code=0.
REQ-028 rst asserted mid-write SHALL abort that write; on that edge, register contents are the reset values.
REQ-029 The first write after reset SHALL occur on the first rising clk edge after rst deasserts.

Configuration
REQ-030 Macro WB_BYPASS_EN, when defined, SHALL enable write-through bypass on the read ports.
REQ-031 With WB_BYPASS_EN defined, a read address matching an enabled same-cycle write SHALL return the value being written (M priority per REQ-017).
REQ-032 Without WB_BYPASS_EN, read ports SHALL return only stored contents; the new value is visible the cycle after the write.

Verification
REQ-033 Reset, then write W_dstE=0 with W_valE=64'h5, W_stat=AOK, W_icode=6 -> next cycle, d_srcA=0 reads 5 and retired=1.
REQ-034 W_dstE=4, W_valE=64'h100, W_dstM=4, W_valM=64'h200 in the same cycle -> reg4 reads 64'h200.
REQ-035 W_dstE=15 with W_valE=64'hFF -> d_srcA=15 reads 0 and no register changes; W_icode=1 with AOK -> retired unchanged.
REQ-036 W_stat=ADR with W_dstE=1 -> Stat=2, halted=1, reg1 unchanged; a subsequent AOK write to reg1 is ignored and retired is frozen.
REQ-037 Preload retired=32'hFFFFFFFF via 2^32-1 AOK ops (or force), then retire one AOK op -> retired=0, Stat=0.
REQ-038 WB_BYPASS_EN defined, W_dstM=3 with W_valM=64'h7 and d_srcB=3 in the same cycle -> d_rvalB=7 that cycle; with the macro undefined, d_rvalB shows the old value and 7 the next cycle.
